// File: rtl/sdram_frame_writer.sv
// Streams one frame of Avalon-ST beats into SDRAM as Avalon-MM write bursts via a 2*BURST_LEN FIFO.
// Optional macro FRAME_WRITER_AUTO_RESTART_EN: loop frames continuously until reset.
module sdram_frame_writer #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 27,
    parameter int BURST_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   frame_base_i,
    input  logic [23:0]             frame_words_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic [DATA_WIDTH-1:0]   st_data_i,
    input  logic                    st_valid_i,
    output logic                    st_ready_o,
    output logic [ADDR_WIDTH-1:0]   sdram_address_o,
    output logic [7:0]              sdram_burstcount_o,
    output logic [DATA_WIDTH-1:0]   sdram_writedata_o,
    output logic [DATA_WIDTH/8-1:0] sdram_byteenable_o,
    output logic                    sdram_write_o,
    input  logic                    sdram_waitrequest_i,
    output logic [1:0]              state_dbg_o
);

    localparam int FIFO_DEPTH = 2 * BURST_LEN;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            blen_q, blen_d;
    logic [7:0]            beat_q, beat_d;
    logic [23:0]           frame_words_q, frame_words_d;
    logic [23:0]           accepted_q, accepted_d;
    logic [23:0]           written_q, written_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [8:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic        push;
    logic        pop;
    logic        fifo_full;
    logic [23:0] remaining;
    logic [7:0]  blen_c;
    logic [23:0] written_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Both ports transfer on a cycle where the source's valid (st_valid_i / sdram_write_o)
    // is high and the sink is ready (st_ready_o / !sdram_waitrequest_i).
    assign push         = st_valid_i && st_ready_o;
    assign pop          = sdram_write_o && !sdram_waitrequest_i;
    assign fifo_full    = (count_q == 9'(FIFO_DEPTH));
    assign remaining    = frame_words_q - written_q;
    assign blen_c       = (remaining >= 24'(BURST_LEN)) ? 8'(BURST_LEN) : remaining[7:0];
    assign written_next = written_q + 24'(blen_q);

`ifdef FRAME_WRITER_AUTO_RESTART_EN
    assign busy_o = (state_q != S_IDLE);
`else
    assign busy_o = (state_q == S_FILL) || (state_q == S_BURST);
`endif
    assign done_o             = (state_q == S_DONE);
    assign st_ready_o         = busy_o && !fifo_full && (accepted_q < frame_words_q);
    assign sdram_write_o      = (state_q == S_BURST);
    assign sdram_address_o    = addr_q;
    assign sdram_burstcount_o = blen_q;
    assign sdram_writedata_o  = mem_q[rd_ptr_q];
    assign sdram_byteenable_o = '1;
    assign state_dbg_o        = state_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        blen_d        = blen_q;
        beat_d        = beat_q;
        frame_words_d = frame_words_q;
        accepted_d    = accepted_q;
        written_d     = written_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (push) begin
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            accepted_d = accepted_q + 24'd1;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 9'd1;
            2'b01:   count_d = count_q - 9'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d        = frame_base_i;
                    frame_words_d = frame_words_i;
                    accepted_d    = '0;
                    written_d     = '0;
                    state_d       = (frame_words_i == 24'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                // A burst only starts once all its beats are buffered, so write never stalls mid-burst.
                if (count_q >= {1'b0, blen_c}) begin
                    blen_d  = blen_c;
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (pop) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == blen_q - 8'd1) begin
                        addr_d    = addr_q + ADDR_WIDTH'(blen_q);
                        written_d = written_next;
                        state_d   = (written_next == frame_words_q) ? S_DONE : S_FILL;
                    end
                end
            end
            S_DONE: begin
`ifdef FRAME_WRITER_AUTO_RESTART_EN
                addr_d        = frame_base_i;
                frame_words_d = frame_words_i;
                accepted_d    = '0;
                written_d     = '0;
                state_d       = (frame_words_i == 24'd0) ? S_DONE : S_FILL;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            blen_q        <= '0;
            beat_q        <= '0;
            frame_words_q <= '0;
            accepted_q    <= '0;
            written_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            blen_q        <= blen_d;
            beat_q        <= beat_d;
            frame_words_q <= frame_words_d;
            accepted_q    <= accepted_d;
            written_q     <= written_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= st_data_i;
        end
    end

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Randomised bench for sdram_frame_writer: a queue-based frame model predicts bursts, data order and handshakes.
module tb_sdram_frame_writer;

    localparam int DW    = 256;
    localparam int AW    = 27;
    localparam int BL    = 16;
    localparam int DEPTH = 2 * BL;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [AW-1:0]   frame_base_i;
    logic [23:0]     frame_words_i;
    logic            busy_o;
    logic            done_o;
    logic [DW-1:0]   st_data_i;
    logic            st_valid_i;
    logic            st_ready_o;
    logic [AW-1:0]   sdram_address_o;
    logic [7:0]      sdram_burstcount_o;
    logic [DW-1:0]   sdram_writedata_o;
    logic [DW/8-1:0] sdram_byteenable_o;
    logic            sdram_write_o;
    logic            sdram_waitrequest_i;
    logic [1:0]      state_dbg_o;

    sdram_frame_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .frame_base_i        (frame_base_i),
        .frame_words_i       (frame_words_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .st_data_i           (st_data_i),
        .st_valid_i          (st_valid_i),
        .st_ready_o          (st_ready_o),
        .sdram_address_o     (sdram_address_o),
        .sdram_burstcount_o  (sdram_burstcount_o),
        .sdram_writedata_o   (sdram_writedata_o),
        .sdram_byteenable_o  (sdram_byteenable_o),
        .sdram_write_o       (sdram_write_o),
        .sdram_waitrequest_i (sdram_waitrequest_i),
        .state_dbg_o         (state_dbg_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: accepted-beat queue plus the burst list a frame must produce.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            exp_cnt_q[$];
    bit            m_busy, m_done, m_gap, m_idle, m_next_done;
    int            m_words, m_acc, m_wr, m_beat, m_occ, m_rem, m_n;
    logic [AW-1:0] m_base;

    logic [AW-1:0] obs_addr_q[$];
    int            obs_cnt_q[$];
    int            obs_beats, obs_done, obs_stall;

    int valid_mode = 0;
    int wait_mode  = 0;
    int stall_left = 0;
    bit s1, s2;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic void model_clear();
        m_busy = 0; m_done = 0; m_gap = 0;
        m_words = 0; m_acc = 0; m_wr = 0; m_beat = 0;
        exp_q.delete(); exp_addr_q.delete(); exp_cnt_q.delete();
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_write", DW'(sdram_write_o), DW'(0));
            chk("rst_busy", DW'(busy_o), DW'(0));
            chk("rst_done", DW'(done_o), DW'(0));
            chk("rst_ready", DW'(st_ready_o), DW'(0));
            chk("rst_addr", DW'(sdram_address_o), DW'(0));
            chk("rst_burstcount", DW'(sdram_burstcount_o), DW'(0));
            chk("rst_byteenable", DW'(sdram_byteenable_o), DW'({(DW/8){1'b1}}));
            chk("rst_state_dbg", DW'(state_dbg_o), DW'(0));
            model_clear();
        end else begin
            m_idle = !m_busy && !m_done;
            m_occ  = m_acc - m_wr;
            chk("busy", DW'(busy_o), DW'(m_busy));
            chk("done", DW'(done_o), DW'(m_done));
            chk("st_ready", DW'(st_ready_o), DW'(m_busy && m_occ < DEPTH && m_acc < m_words));
            chk("byteenable", DW'(sdram_byteenable_o), DW'({(DW/8){1'b1}}));
            if (m_gap) chk("write_gap", DW'(sdram_write_o), DW'(0));
            if (m_beat != 0) chk("write_held_mid_burst", DW'(sdram_write_o), DW'(1));
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write", DW'(sdram_write_o), DW'(0));
            end else if (sdram_write_o) begin
                chk("address", DW'(sdram_address_o), DW'(exp_addr_q[0]));
                chk("burstcount", DW'(sdram_burstcount_o), DW'(exp_cnt_q[0]));
                if (m_beat == 0) chk("burst_buffered", DW'(m_occ >= exp_cnt_q[0]), DW'(1));
                if (exp_q.size() > 0) chk("writedata", sdram_writedata_o, exp_q[0]);
                else chk("write_without_data", DW'(sdram_write_o), DW'(0));
            end

            if (done_o) obs_done++;
            if (sdram_write_o && sdram_waitrequest_i) obs_stall++;
            m_next_done = 0;
            m_gap = 0;
            if (st_valid_i && st_ready_o) begin
                exp_q.push_back(st_data_i);
                m_acc++;
            end
            if (sdram_write_o && !sdram_waitrequest_i && exp_addr_q.size() > 0) begin
                if (m_beat == 0) begin
                    obs_addr_q.push_back(sdram_address_o);
                    obs_cnt_q.push_back(int'(sdram_burstcount_o));
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_wr++; m_beat++; obs_beats++;
                if (m_beat == exp_cnt_q[0]) begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_cnt_q.pop_front());
                    m_beat = 0;
                    m_gap  = 1;
                    if (m_wr == m_words) begin
                        m_busy = 0;
                        m_next_done = 1;
                    end
                end
            end
            if (start_i && m_idle) begin
                m_words = int'(frame_words_i);
                m_acc = 0; m_wr = 0; m_beat = 0;
                exp_q.delete(); exp_addr_q.delete(); exp_cnt_q.delete();
                m_base = frame_base_i;
                m_rem  = m_words;
                while (m_rem > 0) begin
                    m_n = (m_rem > BL) ? BL : m_rem;
                    exp_addr_q.push_back(m_base);
                    exp_cnt_q.push_back(m_n);
                    m_base = m_base + AW'(m_n);
                    m_rem -= m_n;
                end
                if (m_words == 0) m_next_done = 1;
                else m_busy = 1;
            end
            m_done = m_next_done;
        end
    end

    // Stream source: fresh data every cycle, valid always or random.
    initial begin
        st_valid_i = 1'b0;
        st_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            st_valid_i = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            st_data_i  = rand_beat();
        end
    end

    // Slave stall driver: none, random, or scripted 5-cycle first-beat and 3-cycle mid-burst stalls.
    initial begin
        sdram_waitrequest_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (wait_mode)
                0: sdram_waitrequest_i = 1'b0;
                1: sdram_waitrequest_i = ($urandom_range(0, 3) == 0);
                default: begin
                    if (stall_left == 0 && sdram_write_o) begin
                        if (m_beat == 0 && !s1) begin stall_left = 5; s1 = 1; end
                        else if (m_beat == 8 && !s2) begin stall_left = 3; s2 = 1; end
                    end
                    if (stall_left > 0) begin
                        sdram_waitrequest_i = 1'b1;
                        stall_left--;
                    end else begin
                        sdram_waitrequest_i = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic clear_obs();
        obs_addr_q.delete(); obs_cnt_q.delete();
        obs_beats = 0; obs_done = 0; obs_stall = 0;
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int words, input bit poke);
        bit got;
        clear_obs();
        @(posedge clk); #1;
        frame_base_i  = base;
        frame_words_i = 24'(words);
        start_i       = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
            @(negedge clk);
            if (done_o) got = 1;
            else begin
                @(posedge clk); #1;
                start_i = poke && (cyc == 10);
                if (start_i) begin
                    frame_base_i  = 27'h155_5555;
                    frame_words_i = 24'd7;
                end
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("frame_completes", DW'(got), DW'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", DW'(obs_done), DW'(1));
        chk("beats_written", DW'(obs_beats), DW'(words));
    endtask

    task automatic check_bursts(input int n, input logic [AW-1:0] a0, input int c0,
                                input logic [AW-1:0] a1, input int c1);
        chk("burst_total", DW'(obs_addr_q.size()), DW'(n));
        if (n >= 1 && obs_addr_q.size() >= 1) begin
            chk("burst0_addr", DW'(obs_addr_q[0]), DW'(a0));
            chk("burst0_count", DW'(obs_cnt_q[0]), DW'(c0));
        end
        if (n >= 2 && obs_addr_q.size() >= 2) begin
            chk("burst1_addr", DW'(obs_addr_q[1]), DW'(a1));
            chk("burst1_count", DW'(obs_cnt_q[1]), DW'(c1));
        end
    endtask

    initial begin
        bit got;
        int words;
        int nb;
        logic [AW-1:0] base;
        rst = 1'b1;
        start_i = 1'b0;
        frame_base_i = '0;
        frame_words_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two full bursts, continuous stream, no stalls.
        run_frame(27'h100, 32, 0);
        check_bursts(2, 27'h100, 16, 27'h110, 16);

        // Short tail burst, with a start pulse mid-frame that must be ignored.
        run_frame(27'h2000, 20, 1);
        check_bursts(2, 27'h2000, 16, 27'h2010, 4);

        // Scripted slave stalls on the first beat and mid-burst.
        wait_mode = 2; s1 = 0; s2 = 0;
        run_frame(27'h400, 16, 0);
        check_bursts(1, 27'h400, 16, 27'h0, 0);
        chk("stall_cycles", DW'(obs_stall), DW'(8));
        wait_mode = 0;

        // Zero-length frame.
        run_frame(27'h500, 0, 0);
        check_bursts(0, 27'h0, 0, 27'h0, 0);

        // Top of the address space and wrap.
        run_frame(27'h7FF_FFF8, 16, 0);
        check_bursts(1, 27'h7FF_FFF8, 16, 27'h0, 0);
        run_frame(27'h000_0008, 16, 0);
        check_bursts(1, 27'h000_0008, 16, 27'h0, 0);
        run_frame(27'h7FF_FFF8, 32, 0);
        check_bursts(2, 27'h7FF_FFF8, 16, 27'h000_0008, 16);

        // Reset on beat 7 of the first burst aborts the frame.
        clear_obs();
        @(posedge clk); #1;
        frame_base_i = 27'h200; frame_words_i = 24'd32; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 500 && !got; cyc++) begin
            @(posedge clk); #1;
            if (sdram_write_o && m_beat == 7) got = 1;
        end
        chk("beat7_reached", DW'(got), DW'(1));
        rst = 1'b1;
        #1;
        chk("abort_write_low", DW'(sdram_write_o), DW'(0));
        chk("abort_busy_low", DW'(busy_o), DW'(0));
        chk("abort_ready_low", DW'(st_ready_o), DW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_done = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_abort", DW'(obs_done), DW'(0));
        run_frame(27'h300, 16, 0);
        check_bursts(1, 27'h300, 16, 27'h0, 0);

        // Random frames with random stream gaps and slave stalls.
        valid_mode = 1;
        wait_mode  = 1;
        for (int f = 0; f < 6; f++) begin
            words = $urandom_range(1, 70);
            base  = AW'($urandom());
            run_frame(base, words, 0);
            nb = (words + BL - 1) / BL;
            chk("rand_burst_total", DW'(obs_addr_q.size()), DW'(nb));
            if (obs_cnt_q.size() > 0)
                chk("rand_last_count", DW'(obs_cnt_q[obs_cnt_q.size()-1]), DW'(words - BL * (nb - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_frame_writer.md
SDRAM_FRAME_WRITER -- requirements
Module: sdram_frame_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: stream and SDRAM beat width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 27: SDRAM word-address width, in DATA_WIDTH-bit word units.
REQ-003 SHALL have parameter BURST_LEN, default 16: maximum beats per burst, range 1..128.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  sole clock; the sdram clock domain.
- rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have these control ports:
- start_i  in  1  single-cycle frame start request.
- frame_base_i  in  ADDR_WIDTH  first word address of the frame.
- frame_words_i  in  24  frame length in words.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse on frame completion.
REQ-006 SHALL have these Avalon-ST sink ports:
- st_data_i  in  DATA_WIDTH  input beat.
- st_valid_i  in  1  input beat valid.
- st_ready_o  out  1  block can accept a beat.
REQ-007 SHALL have these Avalon-MM write-master ports:
- sdram_address_o  out  ADDR_WIDTH  burst word address.
- sdram_burstcount_o  out  8  beats in the current burst.
- sdram_writedata_o  out  DATA_WIDTH  write beat.
- sdram_byteenable_o  out  DATA_WIDTH/8  byte enables, constant all-ones.
- sdram_write_o  out  1  write request.
- sdram_waitrequest_i  in  1  slave stall.

Function
REQ-008 SHALL contain an internal FIFO of depth 2*BURST_LEN beats.
- A beat is pushed when st_valid_i && st_ready_o.
- A beat is popped when sdram_write_o && !sdram_waitrequest_i.
REQ-009 SHALL drive st_ready_o = busy_o && FIFO not full && words_accepted < frame_words (latched).
REQ-010 SHALL implement the FSM states IDLE, FILL, BURST and DONE.
REQ-011 IDLE: on start_i, SHALL latch frame_base_i and frame_words_i, set words_accepted and words_written to 0, and go to FILL; busy_o SHALL rise the next cycle.
REQ-012 If the latched frame_words is 0, SHALL go IDLE -> DONE directly and issue no write.
REQ-013 FILL: SHALL compute blen = min(BURST_LEN, frame_words - words_written) and go to BURST once FIFO count >= blen.
REQ-014 BURST: SHALL assert sdram_write_o continuously with sdram_burstcount_o = blen.
- sdram_address_o and sdram_burstcount_o SHALL be held stable for the whole burst.
- sdram_writedata_o SHALL be the FIFO head.
REQ-015 SHALL hold all master outputs unchanged while sdram_waitrequest_i is high, on any beat including the first.
REQ-016 On the last accepted beat of a burst, SHALL advance the address by blen (modulo 2^ADDR_WIDTH) and add blen to words_written.
- If words_written then equals frame_words, go to DONE; otherwise go to FILL.
- sdram_write_o SHALL be low for at least one cycle between bursts.
REQ-017 DONE: SHALL pulse done_o for one cycle, drop busy_o, and go to IDLE.
REQ-018 SHALL ignore start_i while busy_o is high or in DONE.
REQ-019 SHALL never deassert sdram_write_o mid-burst, since the FIFO holds a full burst before the burst starts.
REQ-020 Data order SHALL be preserved: the k-th accepted stream beat is written to base+k.

Reset
REQ-021 On rst, SHALL asynchronously force these values, including mid-burst:
- FSM to IDLE.
- FIFO emptied.
- st_ready_o, sdram_write_o, busy_o and done_o to 0.
- sdram_address_o and sdram_burstcount_o to 0.
- sdram_byteenable_o to all-ones.
REQ-022 A burst aborted by reset SHALL NOT be resumed, and no done_o SHALL be issued for it.

Configuration
REQ-023 Macro FRAME_WRITER_AUTO_RESTART_EN:
- When defined, DONE SHALL still pulse done_o, then re-latch frame_base_i and frame_words_i and return to FILL with busy_o held high (continuous frame loop).
- When defined, only rst SHALL stop the loop.
- When undefined, behaviour SHALL be as REQ-017.

Verification
REQ-024 SHALL cover: base=0x100, words=32, BURST_LEN=16, stream always valid, waitrequest=0 -> two bursts at 0x100 and 0x110, burstcount=16, data order intact, one done_o pulse.
REQ-025 SHALL cover: words=20 -> bursts of 16 then 4 beats at base and base+16; st_ready_o low after the 20th accepted beat.
REQ-026 SHALL cover: waitrequest high for 5 cycles on the first beat and 3 cycles mid-burst -> address, burstcount and data stable throughout; no beat lost or duplicated.
REQ-027 SHALL cover: start_i with words=0 -> done_o pulses, no write; start_i pulsed mid-frame -> ignored.
REQ-028 SHALL cover: base=0x7FFFFF8, words=16 -> a single 16-beat burst at 0x7FFFFF8; the next burst address wraps to 0x0000008 (checked under AUTO_RESTART off by a second start at the wrapped base).
REQ-029 SHALL cover: rst asserted on beat 7 of a burst -> sdram_write_o and busy_o low in the same cycle, no done_o; the next start_i restarts cleanly at the new base.
